frame_interp_scheduler: RTL and testbench

- Sequences frame-rate doubling around the combinational chunk averager (`frame_interpolator_averaging`).
- Once a new current frame is complete, reads the last and current frames chunk-by-chunk from two 1-cycle-latency frame buffers and emits the interpolated (averaged) frame, then the current frame unmodified, on a valid/ready chunk stream.
- On completion, pulses a swap so the buffer manager makes current become last.
- Sits between the frame buffer manager and the output scaler/HDMI path.

---
 rtl/frame_interp_scheduler_pkg.sv | 28 ++
 rtl/chunk_out_fifo.sv | 79 +++++++
 rtl/frame_interp_scheduler.sv | 187 ++++++++++++++++++
 tb/tb_frame_interp_scheduler.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_interp_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : frame_interp_scheduler_pkg
// Purpose  : Chunk data types, tags and scheduler states shared by the block.
// Revision : 1.0
// ============================================================================
package frame_interp_scheduler_pkg;

    localparam int INPUT_CELL_SIZE = 8;
    localparam int CHUNK_SIZE      = 4;

    typedef logic [CHUNK_SIZE-1:0][INPUT_CELL_SIZE-1:0] chunk_input;

    typedef struct packed {
        logic sof;
        logic eol;
        logic interp;
    } chunk_tag_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        INTERP = 2'd1,
        PASS   = 2'd2,
        DONE   = 2'd3
    } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/chunk_out_fifo.sv
`default_nettype none
// ============================================================================
// Module   : chunk_out_fifo
// Purpose  : Two-entry tagged output FIFO; count feeds the read credit check.
// Revision : 1.0
// ============================================================================
module chunk_out_fifo
    import frame_interp_scheduler_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       i_push,
    input  chunk_input i_data,
    input  chunk_tag_t i_tag,
    input  logic       i_pop,
    output chunk_input o_data,
    output chunk_tag_t o_tag,
    output logic       o_valid,
    output logic [1:0] o_count
);

    typedef struct packed {
        chunk_input data;
        chunk_tag_t tag;
    } entry_t;

    entry_t     r_head;
    entry_t     r_tail;
    logic [1:0] r_count;
    entry_t     w_in;

    assign w_in = '{data: i_data, tag: i_tag};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= 2'd0;
        end else begin
            case (r_count)
                2'd0: begin
                    if (i_push) begin
                        r_head  <= w_in;
                        r_count <= 2'd1;
                    end
                end
                2'd1: begin
                    case ({i_push, i_pop})
                        2'b10: begin
                            r_tail  <= w_in;
                            r_count <= 2'd2;
                        end
                        2'b01:   r_count <= 2'd0;
                        2'b11:   r_head  <= w_in;
                        default: r_count <= 2'd1;
                    endcase
                end
                2'd2: begin
                    if (i_pop) begin
                        r_head <= r_tail;
                        if (i_push) begin
                            r_tail <= w_in;
                        end else begin
                            r_count <= 2'd1;
                        end
                    end
                end
                default: r_count <= 2'd0;
            endcase
        end
    end

    assign o_data  = r_head.data;
    assign o_tag   = r_head.tag;
    assign o_valid = (r_count != 2'd0);
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/frame_interp_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : frame_interp_scheduler
// Purpose  : Emits interpolated then passthrough frame from two frame buffers.
// Revision : 1.0
// ============================================================================
module frame_interp_scheduler
    import frame_interp_scheduler_pkg::*;
#(
    parameter int CHUNKS_PER_LINE = 40,
    parameter int LINES_PER_FRAME = 720,
    parameter int ADDR_W          = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              frame_ready,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  chunk_input        rd_last_data,
    input  chunk_input        rd_cur_data,
    output chunk_input        avg_last,
    output chunk_input        avg_cur,
    input  chunk_input        avg_result,
    output chunk_input        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sof,
    output logic              out_eol,
    output logic              out_interp,
    output logic              frame_swap,
    output logic              busy,
    output logic              overrun
);

    localparam int                  c_FRAME_CHUNKS = CHUNKS_PER_LINE * LINES_PER_FRAME;
    localparam int                  c_COL_W        = (CHUNKS_PER_LINE > 1) ? $clog2(CHUNKS_PER_LINE) : 1;
    localparam logic [ADDR_W-1:0]   c_LAST_ADDR    = ADDR_W'(c_FRAME_CHUNKS - 1);
    localparam logic [c_COL_W-1:0]  c_LAST_COL     = c_COL_W'(CHUNKS_PER_LINE - 1);

    sched_state_t        r_state;
    sched_state_t        w_state_nxt;
    logic                r_have_last;
    logic                r_pending;
    logic                r_overrun;
    logic                r_sweep_done;
    logic [ADDR_W-1:0]   r_addr;
    logic [c_COL_W-1:0]  r_col;
    logic                r_rd_pend;
    chunk_tag_t          r_rd_tag;
    logic                r_s1_valid;
    chunk_tag_t          r_s1_tag;
    chunk_input          r_avg_last;
    chunk_input          r_avg_cur;

    logic                w_pop;
    logic                w_push;
    logic [1:0]          w_fifo_count;
    logic [1:0]          w_occ;
    logic                w_credit;
    logic                w_last_addr;
    logic                w_drained;
    chunk_tag_t          w_rd_tag;
    chunk_tag_t          w_out_tag;
    chunk_input          w_push_data;

    // Occupancy is counted after this cycle's pop; the averager register stage
    // can hold one word while the FIFO is full, so reads may run back to back.
    assign w_pop       = out_valid & out_ready;
    assign w_occ       = w_fifo_count - {1'b0, w_pop};
    assign w_credit    = ({1'b0, w_occ} + {2'b00, r_rd_pend}) < 3'd2;
    assign w_push      = r_s1_valid & ((w_fifo_count != 2'd2) | w_pop);
    assign w_drained   = ~r_rd_pend & ~r_s1_valid & (w_fifo_count == 2'd0);
    assign w_last_addr = (r_addr == c_LAST_ADDR);
    assign w_rd_tag    = '{sof: (r_addr == '0), eol: (r_col == c_LAST_COL), interp: (r_state == INTERP)};
    assign w_push_data = r_s1_tag.interp ? avg_result : r_avg_cur;

    always_comb begin
        w_state_nxt = r_state;
        rd_en       = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_pending || frame_ready) begin
                    w_state_nxt = r_have_last ? INTERP : PASS;
                end
            end
            INTERP: begin
                rd_en = w_credit;
                if (w_credit && w_last_addr) begin
                    w_state_nxt = PASS;
                end
            end
            PASS: begin
                rd_en = w_credit & ~r_sweep_done;
                if (r_sweep_done && w_drained) begin
                    w_state_nxt = DONE;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_have_last  <= 1'b0;
            r_pending    <= 1'b0;
            r_overrun    <= 1'b0;
            r_sweep_done <= 1'b0;
            r_addr       <= '0;
            r_col        <= '0;
        end else begin
            r_state <= w_state_nxt;
            // A request arriving in the same cycle a pending one is consumed stays queued.
            if (r_state == IDLE) begin
                r_pending <= r_pending & frame_ready;
            end else if (frame_ready) begin
                if (r_pending) begin
                    r_overrun <= 1'b1;
                end
                r_pending <= 1'b1;
            end
            if (r_state == DONE) begin
                r_have_last  <= 1'b1;
                r_sweep_done <= 1'b0;
            end else if ((r_state == PASS) && rd_en && w_last_addr) begin
                r_sweep_done <= 1'b1;
            end
            if (rd_en) begin
                if (w_last_addr) begin
                    r_addr <= '0;
                    r_col  <= '0;
                end else begin
                    r_addr <= r_addr + ADDR_W'(1);
                    r_col  <= (r_col == c_LAST_COL) ? '0 : r_col + c_COL_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_rd_pend  <= 1'b0;
            r_rd_tag   <= '0;
            r_s1_valid <= 1'b0;
            r_s1_tag   <= '0;
            r_avg_last <= '0;
            r_avg_cur  <= '0;
        end else begin
            r_rd_pend <= rd_en;
            r_rd_tag  <= w_rd_tag;
            if (r_rd_pend) begin
                r_avg_last <= rd_last_data;
                r_avg_cur  <= rd_cur_data;
                r_s1_tag   <= r_rd_tag;
                r_s1_valid <= 1'b1;
            end else if (w_push) begin
                r_s1_valid <= 1'b0;
            end
        end
    end

    chunk_out_fifo u_out_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (w_push),
        .i_data  (w_push_data),
        .i_tag   (r_s1_tag),
        .i_pop   (w_pop),
        .o_data  (out_data),
        .o_tag   (w_out_tag),
        .o_valid (out_valid),
        .o_count (w_fifo_count)
    );

    assign rd_addr    = r_addr;
    assign avg_last   = r_avg_last;
    assign avg_cur    = r_avg_cur;
    assign out_sof    = w_out_tag.sof;
    assign out_eol    = w_out_tag.eol;
    assign out_interp = w_out_tag.interp;
    assign frame_swap = (r_state == DONE);
    assign busy       = (r_state != IDLE);
    assign overrun    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_frame_interp_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_frame_interp_scheduler
// Purpose  : Self-checking bench for frame_interp_scheduler (4x2 chunk frames).
// Revision : 1.0
// ============================================================================
module tb_frame_interp_scheduler;
    import frame_interp_scheduler_pkg::*;

    localparam int CPL = 4;
    localparam int LPF = 2;
    localparam int N   = CPL * LPF;
    localparam int AW  = 16;

    typedef struct packed {
        chunk_input data;
        logic       sof;
        logic       eol;
        logic       interp;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          frame_ready = 1'b0;
    logic          out_ready = 1'b0;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    chunk_input    rd_last_data = '0;
    chunk_input    rd_cur_data = '0;
    chunk_input    avg_last, avg_cur, avg_result, out_data;
    logic          out_valid, out_sof, out_eol, out_interp, frame_swap, busy, overrun;

    chunk_input last_mem [N];
    chunk_input cur_mem  [N];

    exp_t exp_q[$];
    bit   m_busy, m_pending, m_overrun, m_have_last;
    int   n_cmp = 0, n_err = 0;
    int   n_swaps = 0, n_acc = 0, n_issued = 0, rd_exp = 0;
    bit   prev_stall = 1'b0;
    exp_t prev_out;
    chunk_input first_interp_data = '0;

    always #5 clk = ~clk;

    frame_interp_scheduler #(
        .CHUNKS_PER_LINE (CPL),
        .LINES_PER_FRAME (LPF),
        .ADDR_W          (AW)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .frame_ready  (frame_ready),
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .rd_last_data (rd_last_data),
        .rd_cur_data  (rd_cur_data),
        .avg_last     (avg_last),
        .avg_cur      (avg_cur),
        .avg_result   (avg_result),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sof      (out_sof),
        .out_eol      (out_eol),
        .out_interp   (out_interp),
        .frame_swap   (frame_swap),
        .busy         (busy),
        .overrun      (overrun)
    );

    function automatic chunk_input chunk_avg(chunk_input a, chunk_input b);
        chunk_input r;
        for (int i = 0; i < CHUNK_SIZE; i++) begin
            r[i] = INPUT_CELL_SIZE'((int'(a[i]) + int'(b[i])) / 2);
        end
        return r;
    endfunction

    // External averager and 1-cycle-latency frame buffers
    assign avg_result = chunk_avg(avg_last, avg_cur);

    always @(posedge clk) begin
        if (rd_en) begin
            rd_last_data <= last_mem[rd_addr[2:0]];
            rd_cur_data  <= cur_mem[rd_addr[2:0]];
        end
    end

    task automatic fill_cur_random();
        for (int a = 0; a < N; a++) cur_mem[a] = chunk_input'($urandom);
    endtask

    task automatic build_frame();
        exp_t e;
        if (m_have_last) begin
            for (int a = 0; a < N; a++) begin
                e = '{data: chunk_avg(last_mem[a], cur_mem[a]), sof: (a == 0),
                      eol: ((a % CPL) == CPL - 1), interp: 1'b1};
                exp_q.push_back(e);
            end
        end
        for (int a = 0; a < N; a++) begin
            e = '{data: cur_mem[a], sof: (a == 0), eol: ((a % CPL) == CPL - 1), interp: 1'b0};
            exp_q.push_back(e);
        end
    endtask

    // Called #1 after a rising edge; pulses frame_ready for one cycle.
    task automatic request();
        frame_ready = 1'b1;
        if (!m_busy) begin
            m_busy = 1'b1;
            build_frame();
        end else if (!m_pending) begin
            m_pending = 1'b1;
        end else begin
            m_overrun = 1'b1;
        end
        @(posedge clk);
        #1;
        frame_ready = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget, input bit rand_ready);
        int c = 0;
        while ((m_busy || busy) && c < budget) begin
            if (rand_ready) out_ready = $urandom_range(0, 1);
            @(posedge clk);
            #1;
            c++;
        end
        n_cmp++;
        assert (c < budget) else begin
            n_err++;
            $error("FAIL %s: still busy after %0d cycles, required idle", tag, c);
        end
    endtask

    task automatic check_zero(input string tag);
        logic [120:0] v;
        v = {rd_en, rd_addr, avg_last, avg_cur, out_data, out_valid, out_sof, out_eol,
             out_interp, frame_swap, busy, overrun};
        n_cmp++;
        assert (v === '0) else begin
            n_err++;
            $error("FAIL %s: outputs=%h required all zero", tag, v);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_busy = 1'b0; m_pending = 1'b0; m_overrun = 1'b0; m_have_last = 1'b0;
        n_acc = 0; n_issued = 0; rd_exp = 0;
    endtask

    // Output monitor / scoreboard
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                n_cmp++;
                assert (out_valid === 1'b1 && {out_data, out_sof, out_eol, out_interp} === prev_out) else begin
                    n_err++;
                    $error("FAIL hold: valid=%b word=%h required valid=1 word=%h", out_valid,
                           {out_data, out_sof, out_eol, out_interp}, prev_out);
                end
            end
            if (rd_en) begin
                n_cmp++;
                assert (rd_addr === AW'(rd_exp)) else begin
                    n_err++;
                    $error("FAIL rd_addr: got %0d required %0d", rd_addr, rd_exp);
                end
                n_cmp++;
                assert ((n_issued - n_acc - int'(out_valid && out_ready)) <= 2) else begin
                    n_err++;
                    $error("FAIL credit: %0d outstanding at rd_en, required <= 2",
                           n_issued - n_acc - int'(out_valid && out_ready));
                end
                n_issued++;
                rd_exp = (rd_exp + 1) % N;
            end
            if (out_valid && out_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    assert (exp_q.size() > 0) else begin
                        n_err++;
                        $error("FAIL extra_chunk: got %h required none", {out_data, out_sof, out_eol, out_interp});
                    end
                end else begin
                    assert ({out_data, out_sof, out_eol, out_interp} === exp_q[0]) else begin
                        n_err++;
                        $error("FAIL chunk: got %h required %h", {out_data, out_sof, out_eol, out_interp}, exp_q[0]);
                    end
                    void'(exp_q.pop_front());
                end
                if (out_sof && out_interp) first_interp_data = out_data;
                n_acc++;
            end
            prev_stall = out_valid && !out_ready;
            prev_out   = {out_data, out_sof, out_eol, out_interp};
            if (frame_swap) begin
                n_cmp++;
                assert (exp_q.size() == 0) else begin
                    n_err++;
                    $error("FAIL swap_early: %0d chunks outstanding, required 0", exp_q.size());
                end
                n_swaps++;
                m_have_last = 1'b1;
                for (int a = 0; a < N; a++) last_mem[a] = cur_mem[a];
                fill_cur_random();
                if (m_pending) begin
                    m_pending = 1'b0;
                    build_frame();
                end else begin
                    m_busy = 1'b0;
                end
            end
        end
    end

    initial begin
        int sw0, acc0, c;
        model_reset();
        for (int a = 0; a < N; a++) last_mem[a] = chunk_input'($urandom);
        fill_cur_random();
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // First frame: passthrough only
        out_ready = 1'b1;
        sw0 = n_swaps;
        request();
        wait_idle("first_frame", 200, 1'b0);
        n_cmp++;
        assert (n_swaps - sw0 == 1 && n_acc == N) else begin
            n_err++;
            $error("FAIL first_frame: swaps=%0d chunks=%0d required 1 and %0d", n_swaps - sw0, n_acc, N);
        end

        // Known-value interpolation
        for (int a = 0; a < N; a++) begin
            last_mem[a] = {CHUNK_SIZE{8'h10}};
            cur_mem[a]  = {CHUNK_SIZE{8'h30}};
        end
        request();
        wait_idle("interp_values", 200, 1'b0);
        n_cmp++;
        assert (first_interp_data === {CHUNK_SIZE{8'h20}}) else begin
            n_err++;
            $error("FAIL interp_value: got %h required %h", first_interp_data, {CHUNK_SIZE{8'h20}});
        end

        // Random backpressure, random data
        for (int f = 0; f < 3; f++) begin
            fill_cur_random();
            request();
            wait_idle("backpressure", 500, 1'b1);
        end

        // Overrun: three extra requests inside one busy period
        sw0 = n_swaps;
        fill_cur_random();
        request();
        for (int k = 0; k < 3; k++) request();
        wait_idle("overrun", 800, 1'b1);
        n_cmp++;
        assert (overrun === m_overrun && overrun === 1'b1) else begin
            n_err++;
            $error("FAIL overrun: got %b required %b", overrun, m_overrun);
        end
        repeat (6) @(posedge clk);
        #1;
        n_cmp++;
        assert (n_swaps - sw0 == 2 && busy === 1'b0) else begin
            n_err++;
            $error("FAIL pending_once: swaps=%0d busy=%b required 2 and 0", n_swaps - sw0, busy);
        end

        // Reset mid-frame
        out_ready = 1'b1;
        acc0 = n_acc;
        fill_cur_random();
        request();
        c = 0;
        while (n_acc - acc0 < 5 && c < 100) begin
            @(posedge clk);
            #1;
            c++;
        end
        n_cmp++;
        assert (c < 100) else begin
            n_err++;
            $error("FAIL mid_reset_wait: %0d chunks accepted, required 5", n_acc - acc0);
        end
        reset_n = 1'b0;
        model_reset();
        sw0 = n_swaps;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        check_zero("mid_reset");
        repeat (5) @(posedge clk);
        #1;
        n_cmp++;
        assert (n_swaps == sw0 && busy === 1'b0) else begin
            n_err++;
            $error("FAIL no_swap_after_reset: swaps=%0d busy=%b required 0 and 0", n_swaps - sw0, busy);
        end
        request();
        wait_idle("post_reset_frame", 200, 1'b0);
        n_cmp++;
        assert (n_swaps - sw0 == 1 && n_acc == N) else begin
            n_err++;
            $error("FAIL post_reset_frame: swaps=%0d chunks=%0d required 1 and %0d", n_swaps - sw0, n_acc, N);
        end

        // Throughput with out_ready held high
        out_ready = 1'b1;
        fill_cur_random();
        acc0 = n_acc;
        request();
        c = 0;
        while (n_acc - acc0 < 2 * N && c < 60) begin
            @(posedge clk);
            c++;
        end
        #1;
        n_cmp++;
        assert (c <= 2 * N + 4) else begin
            n_err++;
            $error("FAIL throughput: %0d cycles for %0d chunks, required <= %0d", c, n_acc - acc0, 2 * N + 4);
        end
        wait_idle("throughput_done", 200, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
